dcache_ctrl: RTL and testbench

//  Initiator side of the cached data-memory interface. Direct-mapped, write-through, no-write-allocate

---
 rtl/dcache_pkg.sv | 15 +
 rtl/dcache_line_store.sv | 65 ++++++
 rtl/dcache_ctrl.sv | 169 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache.
// Optional build macro: DCACHE_STATS_EN (hit/miss counters on dcache_ctrl).
package dcache_pkg;

  localparam int unsigned OFFSET_W = 2;
  localparam int unsigned LINE_W   = 128;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StWrite = 2'd2,
    StGap   = 2'd3
  } state_e;

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays: one combinational read port, a full-line install port
// and a single-word update port. Only the valid bits are reset.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned WORD_W = 32
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic                  rd_valid_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [4*WORD_W-1:0]   rd_line_o,
  input  logic                  inst_en_i,
  input  logic [IDX_W-1:0]      inst_idx_i,
  input  logic [TAG_W-1:0]      inst_tag_i,
  input  logic [4*WORD_W-1:0]   inst_line_i,
  input  logic                  upd_en_i,
  input  logic [IDX_W-1:0]      upd_idx_i,
  input  logic [OFFSET_W-1:0]   upd_off_i,
  input  logic [WORD_W-1:0]     upd_word_i
);

  localparam int unsigned NumLines = 2 ** IDX_W;

  logic [NumLines-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q  [NumLines];
  logic [TAG_W-1:0]    tag_d  [NumLines];
  logic [4*WORD_W-1:0] data_q [NumLines];
  logic [4*WORD_W-1:0] data_d [NumLines];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

  // Next-state of the arrays from the install and word-update ports.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (inst_en_i) begin
      valid_d[inst_idx_i] = 1'b1;
      tag_d[inst_idx_i]   = inst_tag_i;
      data_d[inst_idx_i]  = inst_line_i;
    end
    if (upd_en_i) begin
      data_d[upd_idx_i][upd_off_i*WORD_W +: WORD_W] = upd_word_i;
    end
  end

  // Valid bits clear on reset so an aborted fill never leaves a usable line.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) valid_q <= '0;
    else      valid_q <= valid_d;
  end

  // Tag and data storage carry no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Define DCACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned WORD_W = 32
) (
  input  logic                clk,
  input  logic                RST,
  input  logic                cpu_rd,
  input  logic                cpu_wr,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [WORD_W-1:0]   cpu_wdata,
  output logic [WORD_W-1:0]   cpu_rdata,
  output logic                stall,
  output logic                mem_rd_en,
  output logic                mem_miss,
  output logic                mem_wr_en,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  input  logic [4*WORD_W-1:0] mem_rdata,
  input  logic                mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]         hit_cnt,
  output logic [15:0]         miss_cnt
`endif
);

  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFFSET_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [OFFSET_W-1:0] cpu_off;
  logic [IDX_W-1:0]    cpu_idx;
  logic [TAG_W-1:0]    cpu_tag;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [4*WORD_W-1:0] rd_line;
  logic                hit;
  logic                inst_en;
  logic                upd_en;

  assign cpu_off = cpu_addr[OFFSET_W-1:0];
  assign cpu_idx = cpu_addr[OFFSET_W +: IDX_W];
  assign cpu_tag = cpu_addr[ADDR_W-1 -: TAG_W];
  assign hit     = rd_valid & (rd_tag == cpu_tag);

  dcache_line_store #(
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .WORD_W (WORD_W)
  ) u_store (
    .clk         (clk),
    .RST         (RST),
    .rd_idx_i    (cpu_idx),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_line_o   (rd_line),
    .inst_en_i   (inst_en),
    .inst_idx_i  (mem_addr_q[OFFSET_W +: IDX_W]),
    .inst_tag_i  (mem_addr_q[ADDR_W-1 -: TAG_W]),
    .inst_line_i (mem_rdata),
    .upd_en_i    (upd_en),
    .upd_idx_i   (cpu_idx),
    .upd_off_i   (cpu_off),
    .upd_word_i  (cpu_wdata)
  );

  // Load data straight from the indexed line.
  always_comb begin
    cpu_rdata = rd_line[cpu_off*WORD_W +: WORD_W];
  end

  // Next state, request capture, array write strobes and stall.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    stall       = 1'b0;
    inst_en     = 1'b0;
    upd_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cpu_wr) begin
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          upd_en      = hit;  // store miss leaves the cache untouched
          stall       = 1'b1;
          state_d     = StWrite;
        end else if (cpu_rd && !hit) begin
          mem_addr_d = {cpu_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          stall      = 1'b1;
          state_d    = StFill;
        end
      end
      StFill: begin
        stall = 1'b1;
        if (mem_ready) begin
          inst_en = 1'b1;
          state_d = StGap;
        end
      end
      StWrite: begin
        stall = !mem_ready;
        if (mem_ready) state_d = StGap;
      end
      StGap: begin
        // Enables low for one cycle lets the responder's counter return to zero.
        stall   = cpu_rd | cpu_wr;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_rd_en = (state_q == StFill);
  assign mem_miss  = (state_q == StFill);
  assign mem_wr_en = (state_q == StWrite);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // FSM and captured request registers.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  // Saturating counters: stall-free IDLE read hits and IDLE->FILL transitions.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == StIdle && !cpu_wr && cpu_rd) begin
      if (hit && hit_cnt_q != 16'hFFFF)   hit_cnt_d  = hit_cnt_q + 16'd1;
      if (!hit && miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: Data_mem-style responder with random
// latency, directed scenarios, then random loads/stores against a reference
// model (memory image plus per-line valid/tag).
module tb_dcache_ctrl;

  logic         clk;
  logic         RST;
  logic         cpu_rd, cpu_wr;
  logic [9:0]   cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         stall;
  logic         mem_rd_en, mem_miss, mem_wr_en;
  logic [9:0]   mem_addr;
  logic [31:0]  mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
`ifdef DCACHE_STATS_EN
  logic [15:0]  hit_cnt, miss_cnt;
`endif

  dcache_ctrl dut (
    .clk       (clk),
    .RST       (RST),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_rd_en (mem_rd_en),
    .mem_miss  (mem_miss),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder memory (Data_mem) and bench-side reference state.
  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  bit          mvalid  [16];
  logic [3:0]  mtag    [16];
  int          lat;
  int          rsp_cnt;
  int          checks;
  int          failures;
  int          mhits, mmisses;

  // Line read data presented for the aligned fill address.
  always_comb begin
    logic [9:0] base;
    base      = {mem_addr[9:2], 2'b00};
    mem_rdata = {mem[base + 10'd3], mem[base + 10'd2], mem[base + 10'd1], mem[base]};
  end

  // Responder: counts cycles of an enable, pulses ready once, writes on ready.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= i;
    rsp_cnt   <= 0;
    mem_ready <= 1'b0;
    forever begin
      @(posedge clk or negedge RST);
      if (!RST) begin
        rsp_cnt   <= 0;
        mem_ready <= 1'b0;
      end else begin
        mem_ready <= 1'b0;
        if ((mem_rd_en || mem_wr_en) && !mem_ready) begin
          if (rsp_cnt >= lat) begin
            mem_ready <= 1'b1;
            rsp_cnt   <= 0;
            if (mem_wr_en) mem[mem_addr] <= mem_wdata;
          end else begin
            rsp_cnt <= rsp_cnt + 1;
          end
        end else begin
          rsp_cnt <= 0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // One core request held until stall drops, checked against the model.
  task automatic do_op(input bit wr, input logic [9:0] a, input logic [31:0] d);
    logic [3:0] idx;
    logic [3:0] tg;
    logic [9:0] fill_addr;
    bit         pred_hit, saw_rd, saw_wr, done;
    int         cyc;
    idx       = a[5:2];
    tg        = a[9:6];
    pred_hit  = mvalid[idx] && (mtag[idx] == tg);
    lat       = $urandom_range(0, 3);
    cpu_rd    = !wr;
    cpu_wr    = wr;
    cpu_addr  = a;
    cpu_wdata = d;
    cyc = 0; saw_rd = 0; saw_wr = 0; done = 0; fill_addr = '0;
    while (!done && cyc <= 40) begin
      @(negedge clk);
      if (mem_rd_en) begin
        saw_rd    = 1;
        fill_addr = mem_addr;
      end
      if (mem_wr_en) saw_wr = 1;
      if (!stall) done = 1;
      else cyc++;
    end
    check("op_done", 32'(done), 32'd1);
    if (done) begin
      if (wr) begin
        check("st_wr_en", 32'(saw_wr), 32'd1);
        check("st_no_fill", 32'(saw_rd), 32'd0);
        check("st_addr", 32'(mem_addr), 32'(a));
        check("st_wdata", mem_wdata, d);
        check("st_mem", mem[a], d);
      end else begin
        check("ld_hit", 32'(cyc == 0), 32'(pred_hit));
        check("ld_data", cpu_rdata, ref_mem[a]);
        if (pred_hit) check("hit_no_mem", 32'(saw_rd | saw_wr), 32'd0);
        else          check("fill_addr", 32'(fill_addr), 32'({a[9:2], 2'b00}));
      end
    end
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    @(posedge clk); #1;
    if (wr) begin
      ref_mem[a] = d;
    end else begin
      if (pred_hit) mhits++;
      else          mmisses++;
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
    end
  endtask

  initial begin
    int   bad;
    bit   seen;
    logic [9:0] ra;
    checks = 0; failures = 0; mhits = 0; mmisses = 0; lat = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = i;
    for (int i = 0; i < 16; i++) begin
      mvalid[i] = 1'b0;
      mtag[i]   = '0;
    end
    cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
    RST = 1'b1;
    #3 RST = 1'b0;
    @(negedge clk);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_miss", 32'(mem_miss), 32'd0);
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1 RST = 1'b1;
    @(posedge clk); #1;

    // Directed scenarios.
    do_op(0, 10'h005, '0);
    do_op(0, 10'h004, '0);
    do_op(0, 10'h006, '0);
    do_op(0, 10'h007, '0);
    do_op(1, 10'h006, 32'hDEADBEEF);
    do_op(0, 10'h006, '0);
    do_op(1, 10'h105, 32'h0000_1234);
    do_op(0, 10'h005, '0);
    do_op(0, 10'h105, '0);
    do_op(0, 10'h005, '0);

    // Reset in the middle of a fill.
    lat = 3; cpu_rd = 1'b1; cpu_addr = 10'h3C8; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mem_rd_en) seen = 1;
    end
    check("rst_fill_seen", 32'(seen), 32'd1);
    #2 RST = 1'b0;
    #1;
    check("abort_rd_en", 32'(mem_rd_en), 32'd0);
    check("abort_miss", 32'(mem_miss), 32'd0);
    check("abort_addr", 32'(mem_addr), 32'd0);
    cpu_rd = 1'b0;
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    mhits = 0; mmisses = 0;
    @(posedge clk); #1 RST = 1'b1;
    @(posedge clk); #1;
    do_op(0, 10'h005, '0);
    do_op(0, 10'h3C8, '0);

    // Random traffic over a small tag space so hits and conflicts both occur.
    for (int n = 0; n < 150; n++) begin
      ra = 10'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) do_op(1, ra, $urandom);
      else                           do_op(0, ra, '0);
    end

    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_image", 32'(bad), 32'd0);
`ifdef DCACHE_STATS_EN
    check("hit_cnt", 32'(hit_cnt), 32'(mhits));
    check("miss_cnt", 32'(miss_cnt), 32'(mmisses));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
